// File: rtl/hazard_stall_controller.sv
// Hazard unit: combinational MEM->EX forwarding plus a small FSM that stalls the
// front end on load-use hazards and holds EX while a multi-cycle multiply runs.
module hazard_stall_controller #(
  parameter int unsigned LOAD_STALL_CYCLES = 2,
  parameter int unsigned MULT_CYCLES       = 4
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [4:0] ID_Rs,
  input  logic [4:0] ID_Rt,
  input  logic       ID_UsesRt,
  input  logic       ID_IsMult,
  input  logic [4:0] EX_Rs,
  input  logic [4:0] EX_Rt,
  input  logic       EX_UseImm,
  input  logic       EX_MemRead,
  input  logic [4:0] EX_WriteReg,
  input  logic       MEM_RegWrite,
  input  logic       MEM_MemRead,
  input  logic [4:0] MEM_WriteReg,
  output logic [1:0] ForwardA,
  output logic [1:0] ForwardB,
  output logic       PCWrite,
  output logic       IFID_Write,
  output logic       IDEX_Write,
  output logic       IDEX_Flush,
  output logic       EXMEM_Flush,
  output logic       MultBusy
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    LOAD_STALL = 2'd1,
    MULT_BUSY  = 2'd2
  } state_t;

  localparam logic [3:0] LOAD_RELOAD = 4'(LOAD_STALL_CYCLES - 1);
  localparam logic [3:0] MULT_RELOAD = 4'(MULT_CYCLES - 1);
  localparam bit         LOAD_MULTI  = (LOAD_STALL_CYCLES > 1);

  state_t     state;
  logic [3:0] cnt;
  logic       mem_fwd_ok;
  logic       load_hazard;

  // A load in MEM has no ALU result yet, and r0 is hard-wired, so neither forwards.
  assign mem_fwd_ok  = MEM_RegWrite && !MEM_MemRead && (MEM_WriteReg != 5'd0);

  assign load_hazard = EX_MemRead && (EX_WriteReg != 5'd0) &&
                       ((EX_WriteReg == ID_Rs) || (ID_UsesRt && (EX_WriteReg == ID_Rt)));

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (load_hazard) begin
            cnt <= LOAD_RELOAD;
            if (LOAD_MULTI) state <= LOAD_STALL;
          end else if (ID_IsMult) begin
            cnt   <= MULT_RELOAD;
            state <= MULT_BUSY;
          end
        end
        LOAD_STALL, MULT_BUSY: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= IDLE;
        end
        default: begin
          state <= IDLE;
          cnt   <= 4'd0;
        end
      endcase
    end
  end

  always_comb begin
    ForwardA = 2'b00;
    ForwardB = 2'b00;
    if (!Reset) begin
      if (mem_fwd_ok && (MEM_WriteReg == EX_Rs)) ForwardA = 2'b10;
      if (EX_UseImm)                                  ForwardB = 2'b01;
      else if (mem_fwd_ok && (MEM_WriteReg == EX_Rt)) ForwardB = 2'b10;
    end
  end

  // Stall controls depend on the live hazard in IDLE so the first stall cycle is immediate.
  always_comb begin
    PCWrite     = 1'b1;
    IFID_Write  = 1'b1;
    IDEX_Write  = 1'b1;
    IDEX_Flush  = 1'b0;
    EXMEM_Flush = 1'b0;
    MultBusy    = 1'b0;
    if (!Reset) begin
      case (state)
        IDLE: begin
          if (load_hazard) begin
            PCWrite    = 1'b0;
            IFID_Write = 1'b0;
            IDEX_Flush = 1'b1;
          end
        end
        LOAD_STALL: begin
          PCWrite    = 1'b0;
          IFID_Write = 1'b0;
          IDEX_Flush = 1'b1;
        end
        MULT_BUSY: begin
          PCWrite     = 1'b0;
          IFID_Write  = 1'b0;
          IDEX_Write  = 1'b0;
          EXMEM_Flush = 1'b1;
          MultBusy    = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Bench for hazard_stall_controller: per-cycle expected output vectors are queued
// with the stimulus and compared mid-cycle against the combinational outputs.
module tb_hazard_stall_controller;

  logic       Clk, Reset;
  logic [4:0] ID_Rs, ID_Rt, EX_Rs, EX_Rt, EX_WriteReg, MEM_WriteReg;
  logic       ID_UsesRt, ID_IsMult, EX_UseImm, EX_MemRead, MEM_RegWrite, MEM_MemRead;
  logic [1:0] ForwardA, ForwardB;
  logic       PCWrite, IFID_Write, IDEX_Write, IDEX_Flush, EXMEM_Flush, MultBusy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [9:0] exp_q[$];
  string      tag_q[$];

  // {PCWrite, IFID_Write, IDEX_Write, IDEX_Flush, EXMEM_Flush, MultBusy}
  localparam logic [5:0] C_IDLE = 6'b111000;
  localparam logic [5:0] C_LOAD = 6'b001100;
  localparam logic [5:0] C_MULT = 6'b000011;

  hazard_stall_controller #(.LOAD_STALL_CYCLES(2), .MULT_CYCLES(4)) dut (
    .Clk(Clk), .Reset(Reset),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt), .ID_IsMult(ID_IsMult),
    .EX_Rs(EX_Rs), .EX_Rt(EX_Rt), .EX_UseImm(EX_UseImm), .EX_MemRead(EX_MemRead),
    .EX_WriteReg(EX_WriteReg),
    .MEM_RegWrite(MEM_RegWrite), .MEM_MemRead(MEM_MemRead), .MEM_WriteReg(MEM_WriteReg),
    .ForwardA(ForwardA), .ForwardB(ForwardB),
    .PCWrite(PCWrite), .IFID_Write(IFID_Write), .IDEX_Write(IDEX_Write),
    .IDEX_Flush(IDEX_Flush), .EXMEM_Flush(EXMEM_Flush), .MultBusy(MultBusy)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  function automatic logic [9:0] ex(input logic [1:0] fa, input logic [1:0] fb,
                                    input logic [5:0] ctl);
    return {fa, fb, ctl};
  endfunction

  task automatic check_eq(input string tag, input logic [9:0] got, input logic [9:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got fa/fb/ctl=%b expected %b", tag, got, exp);
    end
  endtask

  // Queue the expectation for this cycle, then compare at the falling edge.
  task automatic step(input string tag, input logic [9:0] exp);
    logic [9:0] e;
    string      t;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(negedge Clk);
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    check_eq(t, {ForwardA, ForwardB, PCWrite, IFID_Write, IDEX_Write,
                 IDEX_Flush, EXMEM_Flush, MultBusy}, e);
    @(posedge Clk);
    #1;
  endtask

  task automatic clear_inputs();
    ID_Rs = 5'd0; ID_Rt = 5'd0; ID_UsesRt = 1'b0; ID_IsMult = 1'b0;
    EX_Rs = 5'd0; EX_Rt = 5'd0; EX_UseImm = 1'b0; EX_MemRead = 1'b0; EX_WriteReg = 5'd0;
    MEM_RegWrite = 1'b0; MEM_MemRead = 1'b0; MEM_WriteReg = 5'd0;
  endtask

  task automatic set_mem_fwd8();
    MEM_RegWrite = 1'b1; MEM_MemRead = 1'b0; MEM_WriteReg = 5'd8;
    EX_Rs = 5'd8; EX_Rt = 5'd8; EX_UseImm = 1'b0;
  endtask

  initial begin
    clear_inputs();
    Reset = 1'b1;
    @(posedge Clk);
    #1;

    // Reset: idle controls, forwarding masked even with a matching MEM write.
    set_mem_fwd8();
    step("reset_outputs", ex(2'b00, 2'b00, C_IDLE));
    clear_inputs();
    Reset = 1'b0;
    step("post_reset_idle", ex(2'b00, 2'b00, C_IDLE));

    // Forwarding patterns.
    EX_UseImm = 1'b1; MEM_RegWrite = 1'b1; MEM_WriteReg = 5'd5; EX_Rt = 5'd5; EX_Rs = 5'd3;
    step("imm_priority", ex(2'b00, 2'b01, C_IDLE));
    clear_inputs(); set_mem_fwd8();
    step("mem_fwd_both", ex(2'b10, 2'b10, C_IDLE));
    MEM_WriteReg = 5'd0; EX_Rs = 5'd0; EX_Rt = 5'd0;
    step("mem_fwd_r0", ex(2'b00, 2'b00, C_IDLE));
    set_mem_fwd8(); MEM_MemRead = 1'b1;
    step("mem_fwd_load", ex(2'b00, 2'b00, C_IDLE));
    set_mem_fwd8(); MEM_RegWrite = 1'b0;
    step("mem_fwd_nowrite", ex(2'b00, 2'b00, C_IDLE));
    set_mem_fwd8(); EX_Rt = 5'd4;
    step("mem_fwd_a_only", ex(2'b10, 2'b00, C_IDLE));
    clear_inputs();

    // Load-use on Rs: two stall cycles, then release.
    EX_MemRead = 1'b1; EX_WriteReg = 5'd9; ID_Rs = 5'd9;
    step("load_stall_c1", ex(2'b00, 2'b00, C_LOAD));
    clear_inputs();
    step("load_stall_c2", ex(2'b00, 2'b00, C_LOAD));
    step("load_stall_done", ex(2'b00, 2'b00, C_IDLE));

    // Rt match without ID_UsesRt is not a hazard; with it, it is.
    EX_MemRead = 1'b1; EX_WriteReg = 5'd9; ID_Rs = 5'd1; ID_Rt = 5'd9; ID_UsesRt = 1'b0;
    step("rt_unused_nostall", ex(2'b00, 2'b00, C_IDLE));
    clear_inputs();
    step("rt_unused_after", ex(2'b00, 2'b00, C_IDLE));
    EX_MemRead = 1'b1; EX_WriteReg = 5'd9; ID_Rs = 5'd1; ID_Rt = 5'd9; ID_UsesRt = 1'b1;
    step("rt_used_c1", ex(2'b00, 2'b00, C_LOAD));
    clear_inputs();
    step("rt_used_c2", ex(2'b00, 2'b00, C_LOAD));
    step("rt_used_done", ex(2'b00, 2'b00, C_IDLE));
    EX_MemRead = 1'b1; EX_WriteReg = 5'd0; ID_Rs = 5'd0;
    step("load_r0_nostall", ex(2'b00, 2'b00, C_IDLE));
    clear_inputs();

    // Multiply: no stall on issue, 3 busy cycles, issue request ignored while busy.
    ID_IsMult = 1'b1;
    step("mult_issue", ex(2'b00, 2'b00, C_IDLE));
    clear_inputs();
    step("mult_busy1", ex(2'b00, 2'b00, C_MULT));
    ID_IsMult = 1'b1; set_mem_fwd8();
    step("mult_busy2_fwd", ex(2'b10, 2'b10, C_MULT));
    clear_inputs();
    step("mult_busy3", ex(2'b00, 2'b00, C_MULT));
    step("mult_done", ex(2'b00, 2'b00, C_IDLE));
    step("mult_done2", ex(2'b00, 2'b00, C_IDLE));

    // Load hazard and multiply together: load wins, multiply re-presented afterwards.
    EX_MemRead = 1'b1; EX_WriteReg = 5'd9; ID_Rs = 5'd9; ID_IsMult = 1'b1;
    step("both_load_c1", ex(2'b00, 2'b00, C_LOAD));
    EX_MemRead = 1'b0; EX_WriteReg = 5'd0;
    step("both_load_c2", ex(2'b00, 2'b00, C_LOAD));
    step("both_mult_issue", ex(2'b00, 2'b00, C_IDLE));
    clear_inputs();
    step("both_busy1", ex(2'b00, 2'b00, C_MULT));
    step("both_busy2", ex(2'b00, 2'b00, C_MULT));
    step("both_busy3", ex(2'b00, 2'b00, C_MULT));
    step("both_done", ex(2'b00, 2'b00, C_IDLE));

    // Reset during the second busy cycle.
    ID_IsMult = 1'b1;
    step("rst_mult_issue", ex(2'b00, 2'b00, C_IDLE));
    clear_inputs();
    step("rst_busy1", ex(2'b00, 2'b00, C_MULT));
    Reset = 1'b1;
    step("rst_during_busy", ex(2'b00, 2'b00, C_IDLE));
    Reset = 1'b0;
    step("rst_after_idle", ex(2'b00, 2'b00, C_IDLE));
    step("rst_after_idle2", ex(2'b00, 2'b00, C_IDLE));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
